// File: rtl/regfile_param_sb.sv
// Parametrised register file with a hardwired zero register, optional write-to-read
// bypass, and a per-register busy scoreboard for RAW hazard detection in decode.
module regfile_param_sb #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               RegWrite,
  input  logic [AW-1:0]                      WriteRegister,
  input  logic [WIDTH-1:0]                   WriteData,
  input  logic [NUM_READ-1:0][AW-1:0]        ReadRegister,
  output logic [NUM_READ-1:0][WIDTH-1:0]     ReadData,
  output logic [NUM_READ-1:0]                ReadBusy,
  input  logic                               MarkBusy,
  input  logic [AW-1:0]                      MarkRegister,
  output logic [DEPTH-1:0][WIDTH-1:0]        reg_out
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  // ZERO_REG may equal DEPTH, which no AW-bit index can reach, disabling the zero register.
  function automatic logic is_zero(input logic [AW-1:0] idx);
    return int'(idx) == ZERO_REG;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
      busy <= '0;
    end else begin
      if (RegWrite && !is_zero(WriteRegister)) begin
        mem[WriteRegister] <= WriteData;
      end
      // A newly issued producer claims the register even if its old producer retires now.
      for (int r = 0; r < DEPTH; r++) begin
        if (MarkBusy && int'(MarkRegister) == r && r != ZERO_REG) begin
          busy[r] <= 1'b1;
        end else if (RegWrite && int'(WriteRegister) == r) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ReadData = '0;
    ReadBusy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      ReadData[k] = mem[ReadRegister[k]];
      ReadBusy[k] = busy[ReadRegister[k]];
      if (BYPASS != 0 && RegWrite && WriteRegister == ReadRegister[k]) begin
        ReadData[k] = WriteData;
        ReadBusy[k] = 1'b0;
      end
      if (is_zero(ReadRegister[k])) begin
        ReadData[k] = '0;
        ReadBusy[k] = 1'b0;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int r = 0; r < DEPTH; r++) begin
      reg_out[r] = (r == ZERO_REG) ? '0 : mem[r];
    end
  end

endmodule

// File: tb/tb_regfile_param_sb.sv
// Scoreboard bench for regfile_param_sb: a default 64x32 instance and a 32x16,
// three-port, no-bypass, no-zero-register instance.
module tb_regfile_param_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic             a_we;
  logic [4:0]       a_wr;
  logic [63:0]      a_wd;
  logic [1:0][4:0]  a_rr;
  logic [1:0][63:0] a_rd;
  logic [1:0]       a_busy;
  logic             a_mb;
  logic [4:0]       a_mr;
  logic [31:0][63:0] a_reg_out;

  // Instance B: WIDTH=32, DEPTH=16, NUM_READ=3, zero register disabled, no bypass
  logic             b_we;
  logic [3:0]       b_wr;
  logic [31:0]      b_wd;
  logic [2:0][3:0]  b_rr;
  logic [2:0][31:0] b_rd;
  logic [2:0]       b_busy;
  logic             b_mb;
  logic [3:0]       b_mr;
  logic [15:0][31:0] b_reg_out;

  regfile_param_sb dut_a (
    .clk(clk), .reset(reset), .RegWrite(a_we), .WriteRegister(a_wr), .WriteData(a_wd),
    .ReadRegister(a_rr), .ReadData(a_rd), .ReadBusy(a_busy), .MarkBusy(a_mb),
    .MarkRegister(a_mr), .reg_out(a_reg_out)
  );

  regfile_param_sb #(.WIDTH(32), .DEPTH(16), .NUM_READ(3), .ZERO_REG(16), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .RegWrite(b_we), .WriteRegister(b_wr), .WriteData(b_wd),
    .ReadRegister(b_rr), .ReadData(b_rd), .ReadBusy(b_busy), .MarkBusy(b_mb),
    .MarkRegister(b_mr), .reg_out(b_reg_out)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;   // 0 data, 1 busy, 2 reg_out
    int          port;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: outputs are combinational, so expectations tagged with the current
  // cycle are compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      logic [63:0] act;
      e = sb.pop_front();
      act = '0;
      if (e.dut == 0) begin
        case (e.kind)
          0: act = a_rd[e.port];
          1: act = {63'd0, a_busy[e.port]};
          default: act = a_reg_out[e.port];
        endcase
      end else begin
        case (e.kind)
          0: act = {32'd0, b_rd[e.port]};
          1: act = {63'd0, b_busy[e.port]};
          default: act = {32'd0, b_reg_out[e.port]};
        endcase
      end
      checks++;
      if (e.cyc != cycle) begin
        failures++;
        $display("[TB] FAIL %s: check missed its cycle (%0d vs %0d)", e.name, e.cyc, cycle);
      end else if (act !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic apply_stimulus(input logic rst, input logic we, input logic [4:0] wr,
                                input logic [63:0] wd, input logic mb, input logic [4:0] mr,
                                input logic [4:0] r0, input logic [4:0] r1);
    @(posedge clk);
    #1;
    reset = rst;
    a_we = we; a_wr = wr; a_wd = wd; a_mb = mb; a_mr = mr;
    a_rr[0] = r0; a_rr[1] = r1;
    b_we = 1'b0; b_wr = '0; b_wd = '0; b_mb = 1'b0; b_mr = '0; b_rr = '0;
  endtask

  task automatic apply_stimulus_b(input logic we, input logic [3:0] wr, input logic [31:0] wd,
                                  input logic mb, input logic [3:0] mr, input logic [3:0] rr);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_we = 1'b0; a_wr = '0; a_wd = '0; a_mb = 1'b0; a_mr = '0; a_rr = '0;
    b_we = we; b_wr = wr; b_wd = wd; b_mb = mb; b_mr = mr;
    for (int k = 0; k < 3; k++) b_rr[k] = rr;
  endtask

  task automatic check_output(input int dut, input int kind, input int port,
                              input logic [63:0] exp, input string name);
    exp_t e;
    e.cyc = cycle; e.dut = dut; e.kind = kind; e.port = port; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  localparam logic [63:0] V3 = 64'h1234_5678_9ABC_DEF0;

  initial begin
    reset = 1'b1;
    a_we = 1'b0; a_wr = '0; a_wd = '0; a_mb = 1'b0; a_mr = '0; a_rr = '0;
    b_we = 1'b0; b_wr = '0; b_wd = '0; b_mb = 1'b0; b_mr = '0; b_rr = '0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset: preload x5, then reset together with a competing write
    apply_stimulus(0, 1, 5, 64'hDEAD, 0, 0, 5, 5);
    check_output(0, 0, 0, 64'hDEAD, "bypass_x5_p0");
    check_output(0, 0, 1, 64'hDEAD, "bypass_x5_p1");
    apply_stimulus(0, 0, 0, 0, 0, 0, 5, 5);
    check_output(0, 0, 0, 64'hDEAD, "preload_x5");
    apply_stimulus(1, 1, 5, 64'h77, 1, 5, 5, 5);
    apply_stimulus(0, 0, 0, 0, 0, 0, 5, 5);
    check_output(0, 0, 0, 64'h0, "reset_data_x5");
    check_output(0, 1, 0, 64'h0, "reset_busy_p0");
    check_output(0, 1, 1, 64'h0, "reset_busy_p1");
    check_output(0, 2, 5, 64'h0, "reset_regout_x5");

    // Write/read x3, both ports, same cycle (bypass) and next cycle
    apply_stimulus(0, 1, 3, V3, 0, 0, 3, 3);
    check_output(0, 0, 0, V3, "bypass_x3_p0");
    check_output(0, 0, 1, V3, "bypass_x3_p1");
    apply_stimulus(0, 0, 0, 0, 0, 0, 3, 3);
    check_output(0, 0, 0, V3, "read_x3_p0");
    check_output(0, 0, 1, V3, "read_x3_p1");
    check_output(0, 1, 0, 64'h0, "busy_x3_clear");
    check_output(0, 2, 3, V3, "regout_x3");

    // Zero register
    apply_stimulus(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 31, 31);
    check_output(0, 0, 0, 64'h0, "zero_same_cycle");
    check_output(0, 1, 0, 64'h0, "zero_busy_same");
    apply_stimulus(0, 0, 0, 0, 0, 0, 31, 3);
    check_output(0, 0, 0, 64'h0, "zero_data");
    check_output(0, 1, 0, 64'h0, "zero_busy");
    check_output(0, 2, 31, 64'h0, "zero_regout");

    // Scoreboard set / clear with bypass
    apply_stimulus(0, 0, 0, 0, 1, 7, 7, 3);
    check_output(0, 1, 0, 64'h0, "busy_x7_before");
    apply_stimulus(0, 0, 0, 0, 0, 0, 7, 7);
    check_output(0, 1, 0, 64'h1, "busy_x7_p0");
    check_output(0, 1, 1, 64'h1, "busy_x7_p1");
    apply_stimulus(0, 1, 7, 64'h42, 0, 0, 7, 3);
    check_output(0, 1, 0, 64'h0, "busy_x7_bypass");
    check_output(0, 0, 0, 64'h42, "data_x7_bypass");
    apply_stimulus(0, 0, 0, 0, 0, 0, 7, 7);
    check_output(0, 1, 0, 64'h0, "busy_x7_cleared");
    check_output(0, 0, 1, 64'h42, "data_x7");

    // Simultaneous mark and write: mark wins
    apply_stimulus(0, 1, 9, 64'h55, 1, 9, 9, 7);
    check_output(0, 0, 0, 64'h55, "data_x9_bypass");
    check_output(0, 1, 0, 64'h0, "busy_x9_bypass");
    apply_stimulus(0, 0, 0, 0, 0, 0, 9, 7);
    check_output(0, 0, 0, 64'h55, "data_x9");
    check_output(0, 1, 0, 64'h1, "busy_x9_set");

    // Reset mid-operation drops pending busy and storage
    apply_stimulus(1, 0, 0, 0, 0, 0, 9, 9);
    apply_stimulus(0, 0, 0, 0, 0, 0, 9, 3);
    check_output(0, 1, 0, 64'h0, "busy_x9_after_reset");
    check_output(0, 0, 0, 64'h0, "data_x9_after_reset");
    check_output(0, 0, 1, 64'h0, "data_x3_after_reset");

    // Instance B: no bypass, three ports, x15 is an ordinary register
    apply_stimulus_b(1, 15, 32'hA5A5A5A5, 0, 0, 15);
    for (int k = 0; k < 3; k++) check_output(1, 0, k, 64'h0, "b_x15_same_cycle");
    apply_stimulus_b(0, 0, 0, 1, 15, 15);
    for (int k = 0; k < 3; k++) check_output(1, 0, k, 64'hA5A5A5A5, "b_x15_next");
    check_output(1, 1, 0, 64'h0, "b_busy_before");
    apply_stimulus_b(1, 15, 32'h1, 0, 0, 15);
    check_output(1, 1, 2, 64'h1, "b_busy_no_bypass");
    check_output(1, 0, 1, 64'hA5A5A5A5, "b_old_data");
    apply_stimulus_b(0, 0, 0, 0, 0, 15);
    check_output(1, 1, 1, 64'h0, "b_busy_cleared");
    check_output(1, 0, 2, 64'h1, "b_new_data");
    check_output(1, 2, 15, 64'h1, "b_regout_x15");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left unchecked", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
